mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath; drives every mux select, write enable and ALU select of the datapath each cycle from the registered instruction's opcode/funct. Sits directly upstream of the datapath and consumes instr[31:26] and instr[5:0] from the instruction register. Adds wait states for the synchronous-read memory and flags unsupported instructions.

---
 rtl/mips_multicycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with wait states for synchronous-read memory.
// Optional jump support is compiled in when the JUMP_EN macro is defined.
module mips_multicycle_ctrl #(
  parameter int MEM_LAT  = 1,
  parameter int ALUSEL_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUSEL_W-1:0] ALUControl,
  output logic [1:0]          PCSrc,
  output logic                Branch,
  output logic                PCWrite,
  output logic                illegal,
  output logic [3:0]          state_dbg
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_t;

  localparam logic [1:0]          MemLat = 2'(MEM_LAT);
  localparam logic [ALUSEL_W-1:0] AluAdd = ALUSEL_W'(4'b0000);
  localparam logic [ALUSEL_W-1:0] AluSub = ALUSEL_W'(4'b0001);
  localparam logic [ALUSEL_W-1:0] AluAnd = ALUSEL_W'(4'b1000);
  localparam logic [ALUSEL_W-1:0] AluOr  = ALUSEL_W'(4'b1001);
  localparam logic [ALUSEL_W-1:0] AluXor = ALUSEL_W'(4'b1010);
  localparam logic [ALUSEL_W-1:0] AluNor = ALUSEL_W'(4'b1011);

  state_t              state_q, state_d;
  logic [1:0]          wcnt_q, wcnt_d;
  logic                isLoad_q, isLoad_d;
  logic [ALUSEL_W-1:0] aluSel_q, aluSel_d;
  logic [ALUSEL_W-1:0] functAlu;
  logic                functOk;
  logic                memDone;
  logic                illegalRaw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      wcnt_q   <= 2'd0;
      isLoad_q <= 1'b0;
      aluSel_q <= AluAdd;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      isLoad_q <= isLoad_d;
      aluSel_q <= aluSel_d;
    end
  end

  always_comb begin
    functOk  = 1'b1;
    functAlu = AluAdd;
    case (funct)
      6'b100000: functAlu = AluAdd;
      6'b100010: functAlu = AluSub;
      6'b100100: functAlu = AluAnd;
      6'b100101: functAlu = AluOr;
      6'b100110: functAlu = AluXor;
      6'b100111: functAlu = AluNor;
      default:   functOk  = 1'b0;
    endcase
  end

  // Opcode and the funct-derived ALU select are captured in DECODE so later
  // instruction-register changes cannot disturb the rest of the sequence.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    isLoad_d   = isLoad_q;
    aluSel_d   = aluSel_q;
    illegalRaw = 1'b0;
    memDone    = (wcnt_q == MemLat);
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = AluAdd;
    PCSrc      = 2'b00;
    Branch     = 1'b0;
    PCWrite    = 1'b0;

    case (state_q)
      StFetch: begin
        ALUSrcB = 2'b01;
        IRWrite = memDone;
        PCWrite = memDone;
        if (memDone) begin
          wcnt_d  = 2'd0;
          state_d = StDecode;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      StDecode: begin
        ALUSrcB = 2'b11;
        case (opcode)
          6'b100011: begin state_d = StMemAdr; isLoad_d = 1'b1; end
          6'b101011: begin state_d = StMemAdr; isLoad_d = 1'b0; end
          6'b000000: begin
            if (functOk) begin
              state_d  = StExecute;
              aluSel_d = functAlu;
            end else begin
              state_d    = StFetch;
              illegalRaw = 1'b1;
            end
          end
          6'b000100: state_d = StBranch;
          6'b001000: state_d = StAddiEx;
`ifdef JUMP_EN
          6'b000010: state_d = StJump;
`endif
          default: begin
            state_d    = StFetch;
            illegalRaw = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = isLoad_q ? StMemRd : StMemWr;
      end
      StMemRd: begin
        IorD = 1'b1;
        if (memDone) begin
          wcnt_d  = 2'd0;
          state_d = StMemWb;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_d  = StFetch;
      end
      StExecute: begin
        ALUSrcA    = 1'b1;
        ALUControl = aluSel_q;
        state_d    = StAluWb;
      end
      StAluWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        ALUControl = AluSub;
        PCSrc      = 2'b01;
        Branch     = 1'b1;
        state_d    = StFetch;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
`ifdef JUMP_EN
      StJump: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        state_d = StFetch;
      end
`endif
      default: state_d = StFetch;
    endcase

    // With MEM_LAT=0 the reset state would otherwise already look like a final fetch cycle.
    if (reset) begin
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      PCWrite  = 1'b0;
      Branch   = 1'b0;
    end
  end

  assign illegal   = illegalRaw & ~reset;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with MEM_LAT=1; per-cycle masks describe each instruction.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [1:0] PCSrc;
  logic       Branch, PCWrite, illegal;
  logic [3:0] state_dbg;

  int checkCount = 0;
  int errorCount = 0;

  mips_multicycle_ctrl #(.MEM_LAT(1), .ALUSEL_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .Branch(Branch), .PCWrite(PCWrite),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the first FETCH cycle; bit i of each mask is the expected value in cycle i.
  task automatic runInstr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input int len, input logic [47:0] seq,
                          input logic [11:0] irM, input logic [11:0] pcM,
                          input logic [11:0] rwM, input logic [11:0] mwM,
                          input logic [11:0] iodM, input logic [11:0] brM,
                          input logic [11:0] ilM, input logic [11:0] rdM,
                          input logic [11:0] m2rM, input int aluIdx,
                          input logic [3:0] expAlu, input logic [1:0] expPcSrc);
    applyStimulus(op, fn);
    for (int i = 0; i < len; i++) begin
      checkOutput($sformatf("%s c%0d state", name, i), state_dbg, seq[4*i +: 4]);
      checkOutput($sformatf("%s c%0d IRWrite", name, i), IRWrite, irM[i]);
      checkOutput($sformatf("%s c%0d PCWrite", name, i), PCWrite, pcM[i]);
      checkOutput($sformatf("%s c%0d RegWrite", name, i), RegWrite, rwM[i]);
      checkOutput($sformatf("%s c%0d MemWrite", name, i), MemWrite, mwM[i]);
      checkOutput($sformatf("%s c%0d IorD", name, i), IorD, iodM[i]);
      checkOutput($sformatf("%s c%0d Branch", name, i), Branch, brM[i]);
      checkOutput($sformatf("%s c%0d illegal", name, i), illegal, ilM[i]);
      checkOutput($sformatf("%s c%0d RegDst", name, i), RegDst, rdM[i]);
      checkOutput($sformatf("%s c%0d MemtoReg", name, i), MemtoReg, m2rM[i]);
      if (i == aluIdx) begin
        checkOutput($sformatf("%s c%0d ALUControl", name, i), ALUControl, expAlu);
        checkOutput($sformatf("%s c%0d PCSrc", name, i), PCSrc, expPcSrc);
      end
      if (i == 3) applyStimulus(~op, ~fn);
      nextCycle();
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(6'b000000, 6'b000000);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state", state_dbg, 4'd0);
    checkOutput("reset IRWrite", IRWrite, 1'b0);
    checkOutput("reset PCWrite", PCWrite, 1'b0);
    checkOutput("reset MemWrite", MemWrite, 1'b0);
    checkOutput("reset RegWrite", RegWrite, 1'b0);
    checkOutput("reset illegal", illegal, 1'b0);
    reset = 1'b0;

    //        name     op         fn         len seq          ir      pc      rw      mw      iod     br      il      rd      m2r  idx alu      pcsrc
    runInstr("lw",    6'b100011, 6'b000000, 7, 48'h4332100, 12'h002, 12'h002, 12'h040, 12'h000, 12'h030, 12'h000, 12'h000, 12'h000, 12'h040, 3, 4'b0000, 2'b00);
    runInstr("sw",    6'b101011, 6'b000000, 5, 48'h52100,   12'h002, 12'h002, 12'h000, 12'h010, 12'h010, 12'h000, 12'h000, 12'h000, 12'h000, 3, 4'b0000, 2'b00);
    runInstr("xor",   6'b000000, 6'b100110, 5, 48'h76100,   12'h002, 12'h002, 12'h010, 12'h000, 12'h000, 12'h000, 12'h000, 12'h010, 12'h000, 3, 4'b1010, 2'b00);
    runInstr("sub",   6'b000000, 6'b100010, 5, 48'h76100,   12'h002, 12'h002, 12'h010, 12'h000, 12'h000, 12'h000, 12'h000, 12'h010, 12'h000, 3, 4'b0001, 2'b00);
    runInstr("and",   6'b000000, 6'b100100, 5, 48'h76100,   12'h002, 12'h002, 12'h010, 12'h000, 12'h000, 12'h000, 12'h000, 12'h010, 12'h000, 3, 4'b1000, 2'b00);
    runInstr("or",    6'b000000, 6'b100101, 5, 48'h76100,   12'h002, 12'h002, 12'h010, 12'h000, 12'h000, 12'h000, 12'h000, 12'h010, 12'h000, 3, 4'b1001, 2'b00);
    runInstr("nor",   6'b000000, 6'b100111, 5, 48'h76100,   12'h002, 12'h002, 12'h010, 12'h000, 12'h000, 12'h000, 12'h000, 12'h010, 12'h000, 3, 4'b1011, 2'b00);
    runInstr("addi",  6'b001000, 6'b000000, 5, 48'hA9100,   12'h002, 12'h002, 12'h010, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 3, 4'b0000, 2'b00);
    runInstr("beq",   6'b000100, 6'b000000, 4, 48'h8100,    12'h002, 12'h002, 12'h000, 12'h000, 12'h000, 12'h008, 12'h000, 12'h000, 12'h000, 3, 4'b0001, 2'b01);
    runInstr("badop", 6'b111111, 6'b000000, 3, 48'h100,     12'h002, 12'h002, 12'h000, 12'h000, 12'h000, 12'h000, 12'h004, 12'h000, 12'h000, 2, 4'b0000, 2'b00);
    runInstr("badfn", 6'b000000, 6'b101010, 3, 48'h100,     12'h002, 12'h002, 12'h000, 12'h000, 12'h000, 12'h000, 12'h004, 12'h000, 12'h000, 2, 4'b0000, 2'b00);
`ifdef JUMP_EN
    runInstr("j",     6'b000010, 6'b000000, 4, 48'hB100,    12'h002, 12'h00A, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 3, 4'b0000, 2'b10);
`else
    runInstr("j",     6'b000010, 6'b000000, 3, 48'h100,     12'h002, 12'h002, 12'h000, 12'h000, 12'h000, 12'h000, 12'h004, 12'h000, 12'h000, 2, 4'b0000, 2'b00);
`endif

    // Reset arriving during a store must kill MemWrite in the same cycle.
    applyStimulus(6'b101011, 6'b000000);
    repeat (4) nextCycle();
    checkOutput("memwr before reset state", state_dbg, 4'd5);
    checkOutput("memwr before reset MemWrite", MemWrite, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("mid reset MemWrite", MemWrite, 1'b0);
    checkOutput("mid reset state", state_dbg, 4'd0);
    checkOutput("mid reset IRWrite", IRWrite, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("post reset c0 state", state_dbg, 4'd0);
    checkOutput("post reset c0 IRWrite", IRWrite, 1'b0);
    checkOutput("post reset c0 PCWrite", PCWrite, 1'b0);
    nextCycle();
    checkOutput("post reset c1 IRWrite", IRWrite, 1'b1);
    checkOutput("post reset c1 PCWrite", PCWrite, 1'b1);
    nextCycle();
    checkOutput("post reset c2 state", state_dbg, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
